loopback_checker: RTL and testbench

LOOPBACK_CHECKER -- requirements
Module: loopback_checker

---
 rtl/loopback_checker_pkg.sv | 22 ++
 rtl/loopback_checker_if.sv | 11 +
 rtl/loopback_checker_bit_history.sv | 25 ++
 rtl/loopback_checker.sv | 114 +++++++++++
 tb/tb_loopback_checker.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/loopback_checker_pkg.sv
// Shared packages for the loopback checker slice: emulated time format,
// run_state encodings and checker-local constants.

package time_package;
    localparam int TIME_W = 64;
    typedef logic [TIME_W-1:0] TIME_FORMAT;
endpackage

package run_state_package;
    // Encodings are externally visible and must not be reordered.
    typedef enum logic [2:0] {
        IN_RESET = 3'b100,
        WAITING  = 3'b000,
        RUNNING  = 3'b010,
        DONE     = 3'b001
    } run_state_t;
endpackage

package loopback_checker_pkg;
    // History address width; tied to the 8-bit loopback_offset port.
    localparam int HIST_AW = 8;
endpackage

// File: rtl/loopback_checker_if.sv
// Bit-stream handshake between the TX/RX source and the loopback checker.

interface loopback_checker_if;
    logic tx_valid;
    logic tx_bit;
    logic rx_valid;
    logic rx_bit;

    modport master (output tx_valid, output tx_bit, output rx_valid, output rx_bit);
    modport slave  (input  tx_valid, input  tx_bit, input  rx_valid, input  rx_bit);
endinterface

// File: rtl/loopback_checker_bit_history.sv
// Circular 1-bit TX history: one synchronous write port, one asynchronous
// read port, so a same-cycle read sees the contents before the write.

module bit_history #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic          wdata,
    input  logic [AW-1:0] raddr,
    output logic          rdata
);
    logic mem [DEPTH];

    // Storage is left uninitialised; the checker's fill guard masks stale entries.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/loopback_checker.sv
// Compares received bits against the transmitted stream delayed by a latched
// offset, counting compared bits and mismatches inside a time window.

module loopback_checker
    import time_package::*;
    import run_state_package::*;
    import loopback_checker_pkg::*;
#(
    parameter int COUNT_WIDTH = 64,
    parameter int HIST_DEPTH  = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  TIME_FORMAT             time_curr,
    input  TIME_FORMAT             start_time,
    input  TIME_FORMAT             stop_time,
    input  logic [7:0]             loopback_offset,
    loopback_checker_if.slave      lb,
    output run_state_t             run_state,
    output logic [COUNT_WIDTH-1:0] total_bits,
    output logic [COUNT_WIDTH-1:0] total_errors,
    output logic                   err_pulse
);
    logic [HIST_AW-1:0] wr_ptr;
    logic [HIST_AW-1:0] rd_addr;
    logic [HIST_AW-1:0] offset_q;
    logic [HIST_AW:0]   fill;
    logic               exp_bit;
    logic               count_en;
    logic               mismatch;

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
        return (&v) ? v : v + COUNT_WIDTH'(1);
    endfunction

    // Offset 0 addresses the most recent bit already in the history.
    assign rd_addr  = wr_ptr - HIST_AW'(1) - offset_q;
    assign count_en = lb.rx_valid && (run_state == RUNNING) && (fill > {1'b0, offset_q});
    assign mismatch = (lb.rx_bit != exp_bit);

    bit_history #(
        .DEPTH (HIST_DEPTH),
        .AW    (HIST_AW)
    ) u_hist (
        .clk   (clk),
        .we    (lb.tx_valid && !rst),
        .waddr (wr_ptr),
        .wdata (lb.tx_bit),
        .raddr (rd_addr),
        .rdata (exp_bit)
    );

    // Run-window FSM; the state register itself drives run_state.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_state <= IN_RESET;
        end else begin
            case (run_state)
                IN_RESET: run_state <= WAITING;
                WAITING: begin
                    if (time_curr >= stop_time) begin
                        run_state <= DONE;
                    end else if (time_curr >= start_time) begin
                        run_state <= RUNNING;
                    end
                end
                RUNNING: begin
                    if (time_curr >= stop_time) begin
                        run_state <= DONE;
                    end
                end
                DONE:    run_state <= DONE;
                default: run_state <= IN_RESET;
            endcase
        end
    end

    // TX write pointer and saturating fill level.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            fill   <= '0;
        end else if (lb.tx_valid) begin
            wr_ptr <= wr_ptr + HIST_AW'(1);
            if (fill != (HIST_AW+1)'(HIST_DEPTH)) begin
                fill <= fill + (HIST_AW+1)'(1);
            end
        end
    end

    // Offset tracks the input until checking starts, then stays frozen.
    always_ff @(posedge clk) begin
        if (rst || (run_state == IN_RESET) || (run_state == WAITING)) begin
            offset_q <= loopback_offset;
        end
    end

    // Saturating bit/error counters and the one-cycle mismatch pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            total_bits   <= '0;
            total_errors <= '0;
            err_pulse    <= 1'b0;
        end else begin
            err_pulse <= count_en && mismatch;
            if (count_en) begin
                total_bits <= sat_inc(total_bits);
                if (mismatch) begin
                    total_errors <= sat_inc(total_errors);
                end
            end
        end
    end
endmodule

// File: tb/tb_loopback_checker.sv
// Directed bench for loopback_checker: a queue-based reference model checked
// every cycle against a 64-bit and a 4-bit counter instance, plus literal
// expectations for each scenario.

module tb_loopback_checker;
    import time_package::*;
    import run_state_package::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    TIME_FORMAT time_curr = '0;
    TIME_FORMAT start_time = '0;
    TIME_FORMAT stop_time = '1;
    logic [7:0] loopback_offset = 8'd0;
    loopback_checker_if lb_if ();

    run_state_t  rs64, rs4;
    logic [63:0] tb64, te64;
    logic [3:0]  tb4, te4;
    logic        ep64, ep4;

    loopback_checker #(.COUNT_WIDTH(64), .HIST_DEPTH(256)) dut64 (
        .clk(clk), .rst(rst), .time_curr(time_curr), .start_time(start_time),
        .stop_time(stop_time), .loopback_offset(loopback_offset), .lb(lb_if),
        .run_state(rs64), .total_bits(tb64), .total_errors(te64), .err_pulse(ep64)
    );

    loopback_checker #(.COUNT_WIDTH(4), .HIST_DEPTH(256)) dut4 (
        .clk(clk), .rst(rst), .time_curr(time_curr), .start_time(start_time),
        .stop_time(stop_time), .loopback_offset(loopback_offset), .lb(lb_if),
        .run_state(rs4), .total_bits(tb4), .total_errors(te4), .err_pulse(ep4)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit              txq[$];
    run_state_t      m_state = IN_RESET;
    int              m_off = 0;
    longint unsigned m_bits = 0;
    longint unsigned m_errs = 0;
    bit              m_pulse = 1'b0;
    bit              m_live = 1'b0;
    bit              m_counted;

    function automatic logic [63:0] sat4(input longint unsigned v);
        return (v > 64'd15) ? 64'd15 : v;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            txq.delete();
            m_state = IN_RESET;
            m_off   = int'(loopback_offset);
            m_bits  = 0;
            m_errs  = 0;
            m_pulse = 1'b0;
            m_live  = 1'b1;
        end else begin
            // The stream as transmitted so far; bit at distance m_off back from the newest.
            m_counted = lb_if.rx_valid && (m_state == RUNNING) && (txq.size() > m_off);
            m_pulse = 1'b0;
            if (m_counted) begin
                m_bits++;
                if (lb_if.rx_bit != txq[txq.size() - 1 - m_off]) begin
                    m_errs++;
                    m_pulse = 1'b1;
                end
            end
            if (m_state == IN_RESET || m_state == WAITING) m_off = int'(loopback_offset);
            if (lb_if.tx_valid) txq.push_back(lb_if.tx_bit);
            if (m_state == IN_RESET) begin
                m_state = WAITING;
            end else if (m_state == WAITING) begin
                if (time_curr >= stop_time) m_state = DONE;
                else if (time_curr >= start_time) m_state = RUNNING;
            end else if (m_state == RUNNING) begin
                if (time_curr >= stop_time) m_state = DONE;
            end
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (m_live) begin
            check("state64", rs64, m_state);
            check("bits64",  tb64, m_bits);
            check("errs64",  te64, m_errs);
            check("pulse64", ep64, m_pulse);
            check("state4",  rs4,  m_state);
            check("bits4",   tb4,  sat4(m_bits));
            check("errs4",   te4,  sat4(m_errs));
            check("pulse4",  ep4,  m_pulse);
        end
    end

    int pulse_seen = 0;
    always @(negedge clk) begin
        if (m_live && ep64 === 1'b1) pulse_seen++;
    end

    // ---------------- stimulus ----------------
    bit         prbs [0:1099];
    TIME_FORMAT tnow = '0;

    task automatic cyc(input logic tv, input logic tb, input logic rv, input logic rb);
        @(negedge clk);
        lb_if.tx_valid = tv;
        lb_if.tx_bit   = tb;
        lb_if.rx_valid = rv;
        lb_if.rx_bit   = rb;
        time_curr      = tnow;
        tnow           = tnow + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input TIME_FORMAT st, input TIME_FORMAT sp, input logic [7:0] off);
        rst             = 1'b1;
        start_time      = st;
        stop_time       = sp;
        loopback_offset = off;
        tnow            = '0;
        repeat (10) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        rst  = 1'b0;
        tnow = '0;
    endtask

    // 40 TX-only cycles, then 1000 RX bits equal to TX delayed by 36 writes.
    task automatic run_prbs(input int inv_a, input int inv_b);
        logic rv, rb;
        for (int n = 0; n < 1040; n++) begin
            rv = (n >= 40);
            rb = rv ? prbs[n - 36] : 1'b0;
            if (rv && ((n - 40) == inv_a || (n - 40) == inv_b)) rb = ~rb;
            cyc(1'b1, prbs[n], rv, rb);
        end
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [6:0] lfsr;
        int         p0;
        lfsr = 7'h7F;
        for (int i = 0; i < 1100; i++) begin
            prbs[i] = lfsr[6];
            lfsr = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
        end
        lb_if.tx_valid = 1'b0;
        lb_if.tx_bit   = 1'b0;
        lb_if.rx_valid = 1'b0;
        lb_if.rx_bit   = 1'b0;

        // Run-state sequence through the time window.
        do_reset(64'd100, 64'd200, 8'd0);
        check("rst_state", rs64, IN_RESET);
        check("rst_bits", tb64, 64'd0);
        check("rst_errs", te64, 64'd0);
        check("rst_pulse", ep64, 1'b0);
        for (int t = 0; t <= 250; t++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            if (t == 0)   check("fsm_t0",   rs64, WAITING);
            if (t == 99)  check("fsm_t99",  rs64, WAITING);
            if (t == 100) check("fsm_t100", rs64, RUNNING);
            if (t == 199) check("fsm_t199", rs64, RUNNING);
            if (t == 200) check("fsm_t200", rs64, DONE);
            if (t == 250) check("fsm_t250", rs64, DONE);
        end

        // Clean PRBS7 loopback at offset 35.
        do_reset(64'd0, '1, 8'd35);
        p0 = pulse_seen;
        run_prbs(-1, -1);
        check("prbs_bits", tb64, 64'd1000);
        check("prbs_model_bits", m_bits, 64'd1000);
        check("prbs_errs", te64, 64'd0);
        check("prbs_pulses", 64'(pulse_seen - p0), 64'd0);

        // Two inverted RX bits.
        do_reset(64'd0, '1, 8'd35);
        p0 = pulse_seen;
        run_prbs(10, 500);
        check("inv_bits", tb64, 64'd1000);
        check("inv_errs", te64, 64'd2);
        check("inv_model_errs", m_errs, 64'd2);
        check("inv_pulses", 64'(pulse_seen - p0), 64'd2);

        // Offset 255: nothing counted until the history holds 256 bits.
        do_reset(64'd0, '1, 8'd255);
        for (int n = 0; n < 300; n++) begin
            cyc(1'b1, prbs[n], 1'b1, (n >= 256) ? prbs[n - 256] : 1'b1);
        end
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("off255_bits", tb64, 64'd44);
        check("off255_errs", te64, 64'd0);

        // 20 mismatches: 4-bit counters saturate at 15.
        do_reset(64'd0, '1, 8'd0);
        for (int n = 0; n < 22; n++) cyc(1'b1, 1'b0, (n >= 2), 1'b1);
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("sat_bits4", tb4, 4'd15);
        check("sat_errs4", te4, 4'd15);
        check("sat_bits64", tb64, 64'd20);
        check("sat_errs64", te64, 64'd20);

        // start after stop: WAITING goes straight to DONE, nothing counted.
        do_reset(64'd300, 64'd200, 8'd0);
        for (int t = 0; t <= 210; t++) begin
            cyc(1'b1, 1'(t % 2), 1'b1, 1'((t + 1) % 2));
            if (t == 199) check("inv_win_t199", rs64, WAITING);
            if (t == 200) check("inv_win_t200", rs64, DONE);
        end
        check("inv_win_state", rs64, DONE);
        check("inv_win_bits", tb64, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
